inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 131 +++++++++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: four single-byte reads are assembled into a
// little-endian word, presented to decode and held until decode accepts it.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        flag_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [2:0]  iss, iss_nxt;
  logic [2:0]  rcv, rcv_nxt;
  logic        vld_p1, vld_p1_nxt;
  logic        vld_p2, vld_p2_nxt;
  logic [23:0] asm_word, asm_word_nxt;
  logic        flag_nxt;
  logic [31:0] pc_o_nxt;
  logic [31:0] inst_nxt;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    iss_nxt      = iss;
    rcv_nxt      = rcv;
    vld_p1_nxt   = vld_p1;
    vld_p2_nxt   = vld_p2;
    asm_word_nxt = asm_word;
    flag_nxt     = flag_o;
    pc_o_nxt     = pc_o;
    inst_nxt     = inst_o;
    mem_req_o    = 1'b0;
    mem_addr_o   = 32'd0;

    // rdy low leaves every *_nxt at its current value, freezing the block
    if (!rst && rdy) begin
      vld_p1_nxt = 1'b0;
      vld_p2_nxt = vld_p1;
      if (jump_i) begin
        // Clearing the in-flight valids drops bytes from pre-redirect requests
        state_nxt  = FETCH;
        pc_nxt     = {jump_addr_i[31:2], 2'b00};
        iss_nxt    = 3'd0;
        rcv_nxt    = 3'd0;
        vld_p1_nxt = 1'b0;
        vld_p2_nxt = 1'b0;
        flag_nxt   = 1'b0;
      end else begin
        case (state)
          FETCH: begin
            if (iss != 3'd4) begin
              mem_req_o  = 1'b1;
              mem_addr_o = pc + {29'd0, iss};
              if (mem_gnt_i) begin
                iss_nxt    = iss + 3'd1;
                vld_p1_nxt = 1'b1;
              end
            end
            if (vld_p2 && rcv != 3'd4) begin
              rcv_nxt = rcv + 3'd1;
              case (rcv[1:0])
                2'd0:    asm_word_nxt[7:0]   = mem_data_i;
                2'd1:    asm_word_nxt[15:8]  = mem_data_i;
                2'd2:    asm_word_nxt[23:16] = mem_data_i;
                default: asm_word_nxt        = asm_word;
              endcase
              // Last byte goes straight to the output word
              if (rcv == 3'd3) begin
                state_nxt = HOLD;
                flag_nxt  = 1'b1;
                pc_o_nxt  = pc;
                inst_nxt  = {mem_data_i, asm_word};
              end
            end
          end
          HOLD: begin
            if (!stall_i) begin
              state_nxt = FETCH;
              pc_nxt    = pc + 32'd4;
              iss_nxt   = 3'd0;
              rcv_nxt   = 3'd0;
              flag_nxt  = 1'b0;
            end
          end
          default: state_nxt = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= 32'd0;
      iss    <= 3'd0;
      rcv    <= 3'd0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      flag_o <= 1'b0;
      pc_o   <= 32'd0;
      inst_o <= 32'd0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      iss    <= iss_nxt;
      rcv    <= rcv_nxt;
      vld_p1 <= vld_p1_nxt;
      vld_p2 <= vld_p2_nxt;
      flag_o <= flag_nxt;
      pc_o   <= pc_o_nxt;
      inst_o <= inst_nxt;
    end
  end

  // Assembly bytes are only read once rcv marks them valid, so no reset needed
  always_ff @(posedge clk) begin
    asm_word <= asm_word_nxt;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed table, hand sequences for multi-cycle corner
// cases, then random traffic against a transaction-level fetch model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, jump_i, mem_gnt_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        flag_o;
  logic [31:0] pc_o, inst_o;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i), .flag_o(flag_o),
    .pc_o(pc_o), .inst_o(inst_o)
  );

  // Memory model: a granted read returns its byte two ready cycles later
  logic [7:0]  mem [4096];
  bit          pv1 = 1'b0, pv2 = 1'b0;
  logic [31:0] pa1 = 32'd0, pa2 = 32'd0;

  always @(posedge clk) begin
    if (rdy) begin
      pv2 <= pv1;
      pa2 <= pa1;
      pv1 <= mem_req_o && mem_gnt_i;
      pa1 <= mem_addr_o;
    end
  end

  assign mem_data_i = pv2 ? mem[pa2[11:0]] : 8'hA5;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[11:0]], mem[a2[11:0]], mem[a1[11:0]], mem[a[11:0]]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic j,
                       input logic [31:0] ja, input logic g);
    rdy = r; stall_i = st; jump_i = j; jump_addr_i = ja; mem_gnt_i = g;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst_req_comb", mem_req_o, 1'b0);
    tick;
    tick;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_flag", flag_o, 1'b0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy, stall, jump;
    logic [31:0] jaddr;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic        flag;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl [9];

  logic [31:0] exp_pc;
  int          grants, cd, accepts;
  bit          exp_flag, exp_req;
  bit          r, st, j, g, rs;
  logic [31:0] ja;

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = 32'd0; mem_gnt_i = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[12'h104] = 8'hDE; mem[12'h105] = 8'hAD;
    mem[12'h106] = 8'hBE; mem[12'h107] = 8'hEF;

    // Straight-line fetch with continuous grant, then immediate accept
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 32'h00100513};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b0, 32'd0, 32'h00100513};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b0, 32'd0, 32'h00100513};

    do_reset;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rdy, tbl[i].stall, tbl[i].jump, tbl[i].jaddr, tbl[i].gnt);
      chk($sformatf("tbl%0d_req", i), mem_req_o, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_flag", i), flag_o, tbl[i].flag);
      chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
      chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].inst);
      tick;
    end

    // Stall for 5 cycles while presenting
    do_reset;
    for (int c = 0; c < 6; c++) begin drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1); tick; end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      chk("stall_flag", flag_o, 1'b1);
      chk("stall_pc", pc_o, 32'd0);
      chk("stall_inst", inst_o, 32'h00100513);
      chk("stall_req", mem_req_o, 1'b0);
      tick;
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("release_flag", flag_o, 1'b1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("after_stall_req", mem_req_o, 1'b1);
    chk("after_stall_addr", mem_addr_o, 32'd4);
    chk("after_stall_flag", flag_o, 1'b0);
    tick;

    // Grant only on odd cycles
    do_reset;
    for (int c = 0; c <= 10; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, (c % 2) == 1);
      chk($sformatf("gnt_c%0d_req", c), mem_req_o, c < 8);
      if (c < 8) chk($sformatf("gnt_c%0d_addr", c), mem_addr_o, 32'(c / 2));
      chk($sformatf("gnt_c%0d_flag", c), flag_o, c == 10);
      if (c == 10) chk("gnt_inst", inst_o, 32'h00100513);
      tick;
    end

    // Redirect in cycle 2 of a fetch
    do_reset;
    for (int c = 0; c <= 9; c++) begin
      drive(1'b1, 1'b0, c == 2, 32'h00000106, 1'b1);
      if (c < 2) chk($sformatf("jmp_c%0d_addr", c), mem_addr_o, 32'(c));
      if (c == 2) chk("jmp_c2_req", mem_req_o, 1'b0);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("jmp_c%0d_req", c), mem_req_o, 1'b1);
        chk($sformatf("jmp_c%0d_addr", c), mem_addr_o, 32'h104 + 32'(c - 3));
      end
      chk($sformatf("jmp_c%0d_flag", c), flag_o, c == 9);
      tick;
    end
    chk("jmp_pc", pc_o, 32'h104);
    chk("jmp_inst", inst_o, 32'hEFBEADDE);

    // Redirect in the same cycle as a HOLD accept at pc 8
    do_reset;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      chk($sformatf("hj_c%0d_flag", c), flag_o, c == 6 || c == 13);
      tick;
    end
    drive(1'b1, 1'b0, 1'b1, 32'h00000200, 1'b1);
    chk("hj_flag", flag_o, 1'b1);
    chk("hj_pc8", pc_o, 32'd8);
    chk("hj_inst8", inst_o, word_at(32'd8));
    tick;
    for (int c = 0; c <= 6; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      if (c == 0) chk("hj_req_addr", mem_addr_o, 32'h200);
      chk($sformatf("hj_r%0d_flag", c), flag_o, c == 6);
      if (c < 6) tick;
    end
    chk("hj_pc_target", pc_o, 32'h200);
    chk("hj_inst_target", inst_o, word_at(32'h200));
    tick;

    // rdy low for 3 cycles mid-fetch
    do_reset;
    for (int c = 0; c < 2; c++) begin drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1); tick; end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("frz_req", mem_req_o, 1'b0);
      chk("frz_flag", flag_o, 1'b0);
      tick;
    end
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      if (c < 2) chk($sformatf("frz_r%0d_addr", c), mem_addr_o, 32'(c + 2));
      chk($sformatf("frz_r%0d_flag", c), flag_o, c == 4);
      if (c < 4) tick;
    end
    chk("frz_inst", inst_o, 32'h00100513);
    chk("frz_pc", pc_o, 32'd0);
    tick;

    // Random traffic: model tracks expected pc, grants issued and byte return time
    do_reset;
    exp_pc = 32'd0; grants = 0; cd = 0; exp_flag = 1'b0; accepts = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom % 10) != 0;
      st = ($urandom % 10) < 3;
      j  = ($urandom % 40) == 0;
      ja = 32'($urandom_range(0, 4000));
      g  = ($urandom % 10) < 7;
      rs = ($urandom % 300) == 0;
      rst = rs;
      drive(r, st, j, ja, g);
      exp_req = !rs && r && !j && !exp_flag && grants < 4;
      chk("rnd_req", mem_req_o, exp_req);
      chk("rnd_addr", mem_addr_o, exp_req ? exp_pc + 32'(grants) : 32'd0);
      chk("rnd_flag", flag_o, exp_flag);
      if (exp_flag) begin
        chk("rnd_pc", pc_o, exp_pc);
        chk("rnd_inst", inst_o, word_at(exp_pc));
      end
      if (rs) begin
        exp_pc = 32'd0; grants = 0; cd = 0; exp_flag = 1'b0;
      end else if (r) begin
        if (j) begin
          exp_pc = {ja[31:2], 2'b00}; grants = 0; cd = 0; exp_flag = 1'b0;
        end else if (exp_flag) begin
          if (!st) begin
            exp_pc = exp_pc + 32'd4; grants = 0; exp_flag = 1'b0; accepts++;
          end
        end else begin
          if (cd > 0) begin
            cd--;
            if (cd == 0) exp_flag = 1'b1;
          end
          if (exp_req && g) begin
            grants++;
            if (grants == 4) cd = 2;
          end
        end
      end
      tick;
    end
    rst = 1'b0;
    chk("rnd_progress", accepts > 30, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
